// File: rtl/hazard_tracker_if.sv
// D-stage hazard query bundle: instruction fields in, stall and forwarding selects out.
// master drives the D-stage fields; slave is the tracker.
interface hazard_tracker_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] A1D;
  logic [ADDR_W-1:0] A2D;
  logic [ADDR_W-1:0] A3D;
  logic [1:0]        TuseD;
  logic [1:0]        TnewD;
  logic              RegWriteD;
  logic              Stall;
  logic [1:0]        FwdRsD;
  logic [1:0]        FwdRtD;
  logic [1:0]        FwdRsE;
  logic [1:0]        FwdRtE;
  logic              FwdRtM;

  modport master (
    output A1D, A2D, A3D, TuseD, TnewD, RegWriteD,
    input  Stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM
  );

  modport slave (
    input  A1D, A2D, A3D, TuseD, TnewD, RegWriteD,
    output Stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM
  );
endinterface

// File: rtl/hazard_tracker.sv
// Tuse/Tnew hazard unit for a 5-stage pipeline: tracks E/M/W destinations and
// produces the D-stage stall plus D/E/M forwarding selects.
module hazard_tracker #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  hazard_tracker_if.slave hz
);

  localparam int unsigned TW = 2;

  // E-stage tracking registers
  logic [ADDR_W-1:0] A1E;
  logic [ADDR_W-1:0] A2E;
  logic [ADDR_W-1:0] A3E;
  logic [TW-1:0]     TnewE;
  logic              RegWriteE;

  // M-stage tracking registers
  logic [ADDR_W-1:0] A2M;
  logic [ADDR_W-1:0] A3M;
  logic [TW-1:0]     TnewM;
  logic              RegWriteM;

  // W-stage tracking registers
  logic [ADDR_W-1:0] A3W;
  logic              RegWriteW;

  // Producer hits: <consumer operand>_<producer stage>
  logic rs_e, rs_m, rs_w;
  logic rt_e, rt_m, rt_w;
  logic ers_m, ers_w;
  logic ert_m, ert_w;
  logic mrt_w;

  logic          stall_rs;
  logic          stall_rt;
  logic          stall_c;
  logic [1:0]    fwd_rs_d;
  logic [1:0]    fwd_rt_d;
  logic [1:0]    fwd_rs_e;
  logic [1:0]    fwd_rt_e;
  logic          fwd_rt_m;

  function automatic logic is_prod(input logic              rw,
                                   input logic [ADDR_W-1:0] a3,
                                   input logic [ADDR_W-1:0] x);
    return rw && (a3 == x) && (x != '0);
  endfunction

  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : TW'(t - TW'(1));
  endfunction

  // Nearest producer wins: E (1), then M (2), then W (3)
  function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
    logic [1:0] s;
    s = 2'd0;
    if (e)      s = 2'd1;
    else if (m) s = 2'd2;
    else if (w) s = 2'd3;
    return s;
  endfunction

  always_comb begin
    rs_e  = is_prod(RegWriteE, A3E, hz.A1D);
    rs_m  = is_prod(RegWriteM, A3M, hz.A1D);
    rs_w  = is_prod(RegWriteW, A3W, hz.A1D);
    rt_e  = is_prod(RegWriteE, A3E, hz.A2D);
    rt_m  = is_prod(RegWriteM, A3M, hz.A2D);
    rt_w  = is_prod(RegWriteW, A3W, hz.A2D);
    ers_m = is_prod(RegWriteM, A3M, A1E);
    ers_w = is_prod(RegWriteW, A3W, A1E);
    ert_m = is_prod(RegWriteM, A3M, A2E);
    ert_w = is_prod(RegWriteW, A3W, A2E);
    mrt_w = is_prod(RegWriteW, A3W, A2M);
  end

  // A younger E producer shadows M, so only its Tnew matters when present
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (rs_e)      stall_rs = (TnewE > hz.TuseD);
    else if (rs_m) stall_rs = (TnewM > hz.TuseD);
    if (rt_e)      stall_rt = (TnewE > hz.TuseD);
    else if (rt_m) stall_rt = (TnewM > hz.TuseD);
    stall_c = stall_rs | stall_rt;
  end

  always_comb begin
    fwd_rs_d = pick(rs_e, rs_m, rs_w);
    fwd_rt_d = pick(rt_e, rt_m, rt_w);
    fwd_rs_e = pick(1'b0, ers_m, ers_w);
    fwd_rt_e = pick(1'b0, ert_m, ert_w);
    fwd_rt_m = mrt_w;
  end

  assign hz.Stall  = stall_c;
  assign hz.FwdRsD = fwd_rs_d;
  assign hz.FwdRtD = fwd_rt_d;
  assign hz.FwdRsE = fwd_rs_e;
  assign hz.FwdRtE = fwd_rt_e;
  assign hz.FwdRtM = fwd_rt_m;

  // E loads a bubble on stall; M and W always advance
  always_ff @(posedge clk) begin
    if (!reset) begin
      A1E       <= '0;
      A2E       <= '0;
      A3E       <= '0;
      TnewE     <= '0;
      RegWriteE <= 1'b0;
      A2M       <= '0;
      A3M       <= '0;
      TnewM     <= '0;
      RegWriteM <= 1'b0;
      A3W       <= '0;
      RegWriteW <= 1'b0;
    end else begin
      if (stall_c) begin
        A1E       <= '0;
        A2E       <= '0;
        A3E       <= '0;
        TnewE     <= '0;
        RegWriteE <= 1'b0;
      end else begin
        A1E       <= hz.A1D;
        A2E       <= hz.A2D;
        A3E       <= hz.A3D;
        TnewE     <= tnew_dec(hz.TnewD);
        RegWriteE <= hz.RegWriteD;
      end
      A2M       <= A2E;
      A3M       <= A3E;
      TnewM     <= tnew_dec(TnewE);
      RegWriteM <= RegWriteE;
      A3W       <= A3M;
      RegWriteW <= RegWriteM;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: age-based in-flight instruction model checked every
// cycle, plus hand-computed expectations for the classic hazard scenarios.
module tb_hazard_tracker;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_tracker_if #(.ADDR_W(AW)) hz ();
  hazard_tracker #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .hz(hz));

  typedef struct {
    int a1;
    int a2;
    int a3;
    bit rw;
    int tnewd;
    int issue;
  } ins_t;

  ins_t hist[$];
  int   edges  = 0;
  int   tests  = 0;
  int   fails  = 0;
  bit   cmp_en = 1'b0;

  // Stages past D: 1 = E, 2 = M, 3 = W
  function automatic int age(int i);
    return edges - hist[i].issue + 1;
  endfunction

  function automatic int tnew_at(int i);
    int t;
    t = hist[i].tnewd - age(i);
    return (t < 0) ? 0 : t;
  endfunction

  // Youngest in-flight writer of addr at least min_age stages past D, -1 if none
  function automatic int nearest(int addr, int min_age);
    int best;
    best = -1;
    if (addr == 0) return -1;
    foreach (hist[i]) begin
      if (hist[i].rw && hist[i].a3 == addr && age(i) >= min_age && age(i) <= 3)
        if (best < 0 || age(i) < age(best)) best = i;
    end
    return best;
  endfunction

  function automatic int at_age(int a);
    int r;
    r = -1;
    foreach (hist[i]) if (age(i) == a) r = i;
    return r;
  endfunction

  function automatic bit op_stall(int addr, int tuse);
    int k;
    k = nearest(addr, 1);
    if (k < 0) return 1'b0;
    return (age(k) <= 2) && (tnew_at(k) > tuse);
  endfunction

  function automatic bit m_stall();
    return op_stall(int'(hz.A1D), int'(hz.TuseD)) || op_stall(int'(hz.A2D), int'(hz.TuseD));
  endfunction

  function automatic int m_sel_d(int addr);
    int k;
    k = nearest(addr, 1);
    return (k < 0) ? 0 : age(k);
  endfunction

  function automatic int m_sel_e(bit rt);
    int c;
    int k;
    c = at_age(1);
    if (c < 0) return 0;
    k = nearest(rt ? hist[c].a2 : hist[c].a1, 2);
    return (k < 0) ? 0 : age(k);
  endfunction

  function automatic int m_sel_m();
    int c;
    int k;
    c = at_age(2);
    if (c < 0) return 0;
    k = nearest(hist[c].a2, 3);
    return (k < 0) ? 0 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model on each edge using the model's own stall decision
  always @(posedge clk) begin
    bit   st;
    ins_t n;
    st = m_stall();
    if (!reset) hist.delete();
    else if (!st) begin
      n.a1    = int'(hz.A1D);
      n.a2    = int'(hz.A2D);
      n.a3    = int'(hz.A3D);
      n.rw    = hz.RegWriteD;
      n.tnewd = int'(hz.TnewD);
      n.issue = edges + 1;
      hist.push_back(n);
    end
    edges++;
    while (hist.size() > 0 && age(0) > 3) void'(hist.pop_front());
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_Stall",  int'(hz.Stall),  int'(m_stall()));
      check("model_FwdRsD", int'(hz.FwdRsD), m_sel_d(int'(hz.A1D)));
      check("model_FwdRtD", int'(hz.FwdRtD), m_sel_d(int'(hz.A2D)));
      check("model_FwdRsE", int'(hz.FwdRsE), m_sel_e(1'b0));
      check("model_FwdRtE", int'(hz.FwdRtE), m_sel_e(1'b1));
      check("model_FwdRtM", int'(hz.FwdRtM), m_sel_m());
    end
  end

  // Present one D-stage instruction for one cycle; returns at the sampling point
  task automatic put(input bit rst, input int a1, input int a2, input int tuse,
                     input int tnew, input bit rw, input int a3);
    @(posedge clk);
    #1;
    reset        = rst;
    hz.A1D       = AW'(a1);
    hz.A2D       = AW'(a2);
    hz.TuseD     = 2'(tuse);
    hz.TnewD     = 2'(tnew);
    hz.RegWriteD = rw;
    hz.A3D       = AW'(a3);
    @(negedge clk);
  endtask

  task automatic nop();
    put(1'b1, 0, 0, 3, 0, 1'b0, 0);
  endtask

  task automatic all_zero(input string name);
    check({name, "_Stall"},  int'(hz.Stall),  0);
    check({name, "_FwdRsD"}, int'(hz.FwdRsD), 0);
    check({name, "_FwdRtD"}, int'(hz.FwdRtD), 0);
    check({name, "_FwdRsE"}, int'(hz.FwdRsE), 0);
    check({name, "_FwdRtE"}, int'(hz.FwdRtE), 0);
    check({name, "_FwdRtM"}, int'(hz.FwdRtM), 0);
  endtask

  initial begin
    hz.A1D = '0; hz.A2D = '0; hz.A3D = '0;
    hz.TuseD = 2'd3; hz.TnewD = 2'd0; hz.RegWriteD = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    cmp_en = 1'b1;

    // Held in reset: any D inputs give no stall and no forwarding
    put(1'b0, 8, 8, 0, 3, 1'b1, 8);
    all_zero("rst_hold1");
    put(1'b0, 8, 8, 0, 3, 1'b1, 8);
    all_zero("rst_hold2");
    nop();
    all_zero("post_reset");

    // add $8 (Tnew 2) then beq $8 (Tuse 0)
    put(1'b1, 1, 2, 1, 2, 1'b1, 8);
    check("add_beq_c0_Stall", int'(hz.Stall), 0);
    put(1'b1, 8, 0, 0, 0, 1'b0, 0);
    check("add_beq_c1_Stall", int'(hz.Stall), 1);
    check("add_beq_c1_FwdRsD", int'(hz.FwdRsD), 1);
    put(1'b1, 8, 0, 0, 0, 1'b0, 0);
    check("add_beq_c2_Stall", int'(hz.Stall), 0);
    check("add_beq_c2_FwdRsD", int'(hz.FwdRsD), 2);
    nop(); nop(); nop();

    // lw $9 (Tnew 3) then add $9 (Tuse 1)
    put(1'b1, 4, 0, 1, 3, 1'b1, 9);
    put(1'b1, 9, 5, 1, 2, 1'b1, 12);
    check("lw_add_c1_Stall", int'(hz.Stall), 1);
    put(1'b1, 9, 5, 1, 2, 1'b1, 12);
    check("lw_add_c2_Stall", int'(hz.Stall), 0);
    check("lw_add_c2_FwdRsD", int'(hz.FwdRsD), 2);
    nop();
    check("lw_add_c3_FwdRsE", int'(hz.FwdRsE), 3);
    nop(); nop(); nop();

    // add $10, nop, sw rt=$10, then a reader of $10 sees W
    put(1'b1, 1, 2, 1, 2, 1'b1, 10);
    nop();
    put(1'b1, 3, 10, 1, 0, 1'b0, 0);
    check("add_sw2_Stall", int'(hz.Stall), 0);
    check("add_sw2_FwdRtD", int'(hz.FwdRtD), 2);
    put(1'b1, 10, 0, 0, 0, 1'b0, 0);
    check("add_sw2_FwdRtE", int'(hz.FwdRtE), 3);
    check("add_sw2_FwdRsD_W", int'(hz.FwdRsD), 3);
    nop(); nop(); nop();

    // add $10 immediately followed by sw rt=$10: store data from W in M
    put(1'b1, 1, 2, 1, 2, 1'b1, 10);
    put(1'b1, 3, 10, 1, 0, 1'b0, 0);
    check("add_sw1_Stall", int'(hz.Stall), 0);
    check("add_sw1_FwdRtD", int'(hz.FwdRtD), 1);
    nop();
    check("add_sw1_FwdRtE", int'(hz.FwdRtE), 2);
    nop();
    check("add_sw1_FwdRtM", int'(hz.FwdRtM), 1);
    nop(); nop();

    // Writes to $0 never stall or forward
    put(1'b1, 1, 0, 1, 3, 1'b1, 0);
    put(1'b1, 0, 0, 0, 0, 1'b0, 0);
    all_zero("zero_reg");
    nop(); nop(); nop();

    // Tuse 3: no stall even right behind a load
    put(1'b1, 4, 0, 1, 3, 1'b1, 7);
    put(1'b1, 7, 7, 3, 0, 1'b0, 0);
    check("tuse3_Stall", int'(hz.Stall), 0);
    check("tuse3_FwdRtD", int'(hz.FwdRtD), 1);
    nop(); nop(); nop();

    // ori $11, lw $11, add $11: the younger lw governs
    put(1'b1, 1, 0, 1, 2, 1'b1, 11);
    put(1'b1, 2, 0, 1, 3, 1'b1, 11);
    check("ori_lw_Stall", int'(hz.Stall), 0);
    put(1'b1, 11, 3, 1, 2, 1'b1, 13);
    check("ori_lw_add_c1_Stall", int'(hz.Stall), 1);
    check("ori_lw_add_c1_FwdRsD", int'(hz.FwdRsD), 1);
    put(1'b1, 11, 3, 1, 2, 1'b1, 13);
    check("ori_lw_add_c2_Stall", int'(hz.Stall), 0);
    check("ori_lw_add_c2_FwdRsD", int'(hz.FwdRsD), 2);
    nop();
    check("ori_lw_add_c3_FwdRsE", int'(hz.FwdRsE), 3);
    nop(); nop(); nop();

    // Reset lands on the load-use stall edge
    put(1'b1, 4, 0, 1, 3, 1'b1, 9);
    put(1'b0, 9, 5, 1, 2, 1'b1, 12);
    check("rst_stall_c1_Stall", int'(hz.Stall), 1);
    put(1'b1, 9, 5, 1, 2, 1'b1, 12);
    all_zero("rst_stall_c2");
    nop();
    all_zero("rst_stall_c3");

    // Normal operation after reset
    put(1'b1, 1, 2, 1, 2, 1'b1, 8);
    put(1'b1, 0, 8, 0, 0, 1'b0, 0);
    check("resume_Stall", int'(hz.Stall), 1);
    check("resume_FwdRtD", int'(hz.FwdRtD), 1);
    nop(); nop(); nop();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have ports A1D and A2D, input, ADDR_W bits: rs and rt read addresses of the D-stage instruction.
REQ-005 The block SHALL have port TuseD, input, 2 bits: cycles until D-stage operands are consumed; 3 means no use.
REQ-006 The block SHALL have port TnewD, input, 2 bits: cycles until the D-stage result exists, counted from D.
REQ-007 The block SHALL have ports RegWriteD (input, 1 bit) and A3D (input, ADDR_W bits): write enable and destination of the D-stage instruction.
REQ-008 The block SHALL have port Stall, output, 1 bit: freeze F/D and inject a bubble into E.
REQ-009 The block SHALL have ports FwdRsD and FwdRtD, output, 2 bits each: D-stage operand source; 0 = register file, 1 = E, 2 = M, 3 = W.
REQ-010 The block SHALL have ports FwdRsE and FwdRtE (output, 2 bits each) and FwdRtM (output, 1 bit): E-stage operand source (0 = reg value, 2 = M, 3 = W) and M-stage store-data source (0 = reg value, 1 = W).

Function
REQ-011 The block SHALL hold E-stage registers A1E, A2E, A3E, TnewE, RegWriteE; M-stage registers A2M, A3M, TnewM, RegWriteM; and W-stage registers A3W, RegWriteW.
REQ-012 On each non-stalled edge, the E-stage registers SHALL load A1D, A2D, A3D, RegWriteD, and TnewE = max(TnewD-1, 0).
REQ-013 On a stalled edge, the E-stage registers SHALL load a bubble: all address fields 0, RegWriteE 0, TnewE 0.
REQ-014 M and W SHALL advance every edge regardless of Stall: M loads from E with TnewM = max(TnewE-1, 0); W loads A3M and RegWriteM.
REQ-015 A stage SHALL count as a producer for address X only when its RegWrite is 1, its A3 equals X, and X is nonzero.
REQ-016 Stall SHALL be combinational and equal 1 iff, for A1D or A2D, E is a producer with TnewE > TuseD, or M is a producer with TnewM > TuseD.
REQ-017 When TuseD = 3, Stall SHALL be 0 for every TnewE and TnewM value.
REQ-018 Each forwarding select SHALL name the nearest downstream producer stage (order E, M, W for D; M, W for E; W for M), or 0 when there is no producer.
REQ-019 A forwarding select SHALL NOT consider Tnew; while the selected stage has Tnew > 0, the consumer is guaranteed to be stalled or not yet using the value.
REQ-020 Address 0 SHALL never produce a stall or a nonzero forwarding select.
REQ-021 When E and M both produce the same address, the younger producer (E) SHALL win for both stall evaluation and forwarding.

Reset
REQ-022 When reset = 0 at a rising edge, all E, M and W registers SHALL clear to 0, regardless of Stall.
REQ-023 In the cycle after reset, Stall and every forwarding select SHALL be 0 for any D-stage inputs.
REQ-024 Reset asserted mid-stall SHALL take priority; the stall SHALL drop in the next cycle, and no bubble or retained state SHALL survive.

Verification
REQ-025 Producer add $8 (TnewD=2) is followed by beq reading $8 (TuseD=0) -> Stall=1 for exactly 1 cycle, then FwdRsD=2.
REQ-026 Producer lw $9 (TnewD=3) is followed by add reading $9 (TuseD=1) -> Stall=1 for 1 cycle; when the add reaches E, FwdRsE=3.
REQ-027 Producer add $10 is followed by sw with rt=$10 two instructions later -> Stall=0; FwdRtE=3, or FwdRtM=1 one cycle later.
REQ-028 Producer writes $0 with TnewD=3, and the consumer reads $0 with TuseD=0 -> Stall=0 and all selects are 0.
REQ-029 Back-to-back writes of $11 (ori, then lw), followed by an add reading $11 -> E (lw) wins: Stall=1, then FwdRsE=3 after the bubble.
REQ-030 Reset is asserted during the stall of REQ-026 -> the next cycle shows Stall=0 and all selects 0; normal operation resumes after reset deassert.
